// File: rtl/cc_register_bank.sv
// ARC-style register bank: two combinational read ports, one synchronous write port,
// dedicated PC/IR views and a 4-bit PSR loaded from the ALU's active-low flags.
module cc_register_bank #(
  parameter int DATAWIDTH_BUS     = 32,
  parameter int DATAWIDTH_REGADDR = 6,
  parameter int NUM_REGS          = 38,
  parameter int PC_INDEX          = 32,
  parameter int IR_INDEX          = 37
) (
  input  logic                         CC_REGBANK_CLOCK_50,
  input  logic                         CC_REGBANK_RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]     CC_REGBANK_DataBUSC_In,
  input  logic [DATAWIDTH_REGADDR-1:0] CC_REGBANK_AddrA_In,
  input  logic [DATAWIDTH_REGADDR-1:0] CC_REGBANK_AddrB_In,
  input  logic [DATAWIDTH_REGADDR-1:0] CC_REGBANK_AddrC_In,
  input  logic                         CC_REGBANK_WriteEn_In,
  input  logic                         CC_REGBANK_PSRLoad_In,
  input  logic [3:0]                   CC_REGBANK_FlagsLow_In,
  output logic [DATAWIDTH_BUS-1:0]     CC_REGBANK_DataBUSA_Out,
  output logic [DATAWIDTH_BUS-1:0]     CC_REGBANK_DataBUSB_Out,
  output logic [DATAWIDTH_BUS-1:0]     CC_REGBANK_PC_Out,
  output logic [DATAWIDTH_BUS-1:0]     CC_REGBANK_IR_Out,
  output logic [3:0]                   CC_REGBANK_PSR_Out
);

  // r0 is hardwired to zero, so storage starts at index 1.
  logic [DATAWIDTH_BUS-1:0] regs_q [1:NUM_REGS-1];
  logic [DATAWIDTH_BUS-1:0] regs_d [1:NUM_REGS-1];
  logic [3:0]               psr_q;
  logic [3:0]               psr_d;
  logic [DATAWIDTH_BUS-1:0] rd_a;
  logic [DATAWIDTH_BUS-1:0] rd_b;

  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (CC_REGBANK_WriteEn_In && (CC_REGBANK_AddrC_In == DATAWIDTH_REGADDR'(i))) begin
        regs_d[i] = CC_REGBANK_DataBUSC_In;
      end
    end
  end

  always_comb begin
    psr_d = psr_q;
    if (CC_REGBANK_PSRLoad_In) begin
      psr_d = ~CC_REGBANK_FlagsLow_In;
    end
  end

  always_ff @(posedge CC_REGBANK_CLOCK_50) begin
    if (CC_REGBANK_RESET_InHigh) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      psr_q <= 4'b0000;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      psr_q <= psr_d;
    end
  end

  // Selectors of 0 or beyond the implemented range match no entry and read as zero.
  always_comb begin
    rd_a = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (CC_REGBANK_AddrA_In == DATAWIDTH_REGADDR'(i)) begin
        rd_a = regs_q[i];
      end
    end
  end

  always_comb begin
    rd_b = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (CC_REGBANK_AddrB_In == DATAWIDTH_REGADDR'(i)) begin
        rd_b = regs_q[i];
      end
    end
  end

  assign CC_REGBANK_DataBUSA_Out = rd_a;
  assign CC_REGBANK_DataBUSB_Out = rd_b;
  assign CC_REGBANK_PC_Out       = regs_q[PC_INDEX];
  assign CC_REGBANK_IR_Out       = regs_q[IR_INDEX];
  assign CC_REGBANK_PSR_Out      = psr_q;

endmodule

// File: tb/tb_cc_register_bank.sv
// Scoreboard bench for cc_register_bank: stimulus pushes expected outputs from an
// array-based reference model, a negedge monitor pops and compares them.
module tb_cc_register_bank;

  localparam int NREGS = 38;

  logic        clk;
  logic        rst;
  logic [31:0] data_c;
  logic [5:0]  addr_a;
  logic [5:0]  addr_b;
  logic [5:0]  addr_c;
  logic        we;
  logic        psr_ld;
  logic [3:0]  flags_low;
  logic [31:0] bus_a;
  logic [31:0] bus_b;
  logic [31:0] pc_out;
  logic [31:0] ir_out;
  logic [3:0]  psr_out;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [3:0]  psr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [64];
  logic [3:0]  model_psr;
  int          n_checks;
  int          n_fails;

  cc_register_bank dut (
    .CC_REGBANK_CLOCK_50     (clk),
    .CC_REGBANK_RESET_InHigh (rst),
    .CC_REGBANK_DataBUSC_In  (data_c),
    .CC_REGBANK_AddrA_In     (addr_a),
    .CC_REGBANK_AddrB_In     (addr_b),
    .CC_REGBANK_AddrC_In     (addr_c),
    .CC_REGBANK_WriteEn_In   (we),
    .CC_REGBANK_PSRLoad_In   (psr_ld),
    .CC_REGBANK_FlagsLow_In  (flags_low),
    .CC_REGBANK_DataBUSA_Out (bus_a),
    .CC_REGBANK_DataBUSB_Out (bus_b),
    .CC_REGBANK_PC_Out       (pc_out),
    .CC_REGBANK_IR_Out       (ir_out),
    .CC_REGBANK_PSR_Out      (psr_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [5:0] a);
    if (a == 6'd0 || int'(a) >= NREGS) return 32'h0;
    return model_mem[a];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, records what the outputs must show before the
  // coming edge, then advances the model across that edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [5:0] ac,
                               input logic [31:0] d, input logic [5:0] aa,
                               input logic [5:0] ab, input logic pl, input logic [3:0] fl);
    exp_t e;
    rst = r; we = w; addr_c = ac; data_c = d;
    addr_a = aa; addr_b = ab; psr_ld = pl; flags_low = fl;
    e.a   = model_read(aa);
    e.b   = model_read(ab);
    e.pc  = model_mem[32];
    e.ir  = model_mem[37];
    e.psr = model_psr;
    exp_q.push_back(e);
    if (r) begin
      for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
      model_psr = 4'b0000;
    end else begin
      if (w && ac != 6'd0 && int'(ac) < NREGS) model_mem[ac] = d;
      if (pl) model_psr = ~fl;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("busA", bus_a, e.a);
        checkOutput("busB", bus_b, e.b);
        checkOutput("pc", pc_out, e.pc);
        checkOutput("ir", ir_out, e.ir);
        checkOutput("psr", {28'h0, psr_out}, {28'h0, e.psr});
      end
    end
  end

  initial begin : stimulus
    int budget;
    n_checks = 0; n_fails = 0;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    model_psr = 4'b0000;
    rst = 1'b1; we = 1'b0; psr_ld = 1'b0; flags_low = 4'hF;
    addr_a = '0; addr_b = '0; addr_c = '0; data_c = '0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 6'd0, 32'h0, 6'd0, 6'd0, 1'b0, 4'hF);

    // every address, including the unimplemented ones, reads zero after reset
    for (int a = 0; a < 64; a++)
      applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 6'(a), 6'(63 - a), 1'b0, 4'hF);

    // write-through has no bypass: old value before the edge, new value after
    applyStimulus(1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 6'd5, 6'd0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 6'd5, 6'd0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 6'd5, 6'd5, 1'b0, 4'h0);

    applyStimulus(1'b0, 1'b1, 6'd1, 32'h11111111, 6'd0, 6'd0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 6'd37, 32'h37373737, 6'd1, 6'd0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 6'd0, 32'h12345678, 6'd1, 6'd37, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 6'd40, 32'h12345678, 6'd0, 6'd40, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 6'd0, 6'd40, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 6'd1, 6'd37, 1'b0, 4'h0);

    applyStimulus(1'b0, 1'b1, 6'd32, 32'h00000800, 6'd32, 6'd37, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 6'd37, 32'h8A00C005, 6'd32, 6'd37, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 6'd32, 6'd37, 1'b0, 4'h0);

    // back-to-back writes to the same register: the last one wins
    applyStimulus(1'b0, 1'b1, 6'd9, 32'hAAAA0001, 6'd9, 6'd9, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 6'd9, 32'hAAAA0002, 6'd9, 6'd9, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 6'd9, 6'd9, 1'b0, 4'h0);

    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 6'd0, 6'd0, 1'b1, 4'b0110);
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 6'd0, 6'd0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 6'd0, 6'd0, 1'b0, 4'b0000);

    // reset beats a simultaneous write and PSR load
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 6'd7, 6'd32, 1'b1, 4'b0101);
    applyStimulus(1'b1, 1'b1, 6'd7, 32'hFFFFFFFF, 6'd7, 6'd37, 1'b1, 4'b0000);
    applyStimulus(1'b0, 1'b1, 6'd7, 32'hFFFFFFFF, 6'd7, 6'd32, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 6'd7, 6'd37, 1'b0, 4'h0);

    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom), 6'($urandom_range(0, 63)),
                    $urandom, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                    1'($urandom), 4'($urandom));
    end
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 6'd32, 6'd37, 1'b0, 4'h0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
